// File: rtl/if_stage_pkg.sv
// if_stage_pkg
//   Shared definitions for the instruction-fetch stage: FSM state encoding,
//   the bubble instruction and the default reset PC.
package if_stage_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2,
    S_DROP = 2'd3
  } fetch_state_t;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

  // Word-align an address by forcing bits [1:0] to zero.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage.sv
// if_stage
//   Instruction-fetch stage of a 5-stage RV32I pipeline. Owns the PC,
//   talks to instruction memory over a single-outstanding req/resp port,
//   buffers one fetched instruction and presents it to the IF/ID register.
//
//   State | meaning
//   ------+-----------------------------------------------
//   IDLE  | nothing outstanding, buffer empty (requesting)
//   WAIT  | request outstanding, buffer empty
//   FULL  | buffer holds a valid instruction, nothing outstanding
//   DROP  | request outstanding, its response will be discarded
//
// Ports
//   clk, rst_n        clock, async active-low reset
//   stallf            hazard-unit stall (hold PC and held instruction)
//   pcsrce, pctargete redirect request and target from execute
//   imem_req/addr     request to instruction memory
//   imem_ready        memory accepts the request this cycle
//   imem_rvalid/rdata in-order response from instruction memory
//   rdf, pcf          instruction and its PC towards IF/ID
//   pcplus4f          pcf + 4
//   fetch_valid       rdf holds a real instruction
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stallf,
  input  logic        pcsrce,
  input  logic [31:0] pctargete,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] rdf,
  output logic [31:0] pcf,
  output logic [31:0] pcplus4f,
  output logic        fetch_valid
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  ibuf;
  logic [31:0]  target;
  logic [31:0]  pc_next_seq;

  assign target      = word_align(pctargete);
  assign pc_next_seq = pc + 32'd4;

  // Request is combinational on the redirect/stall inputs so that the next
  // fetch goes out in the same cycle the held instruction is consumed.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc;
    case (state)
      S_IDLE: begin
        imem_req  = 1'b1;
        imem_addr = pcsrce ? target : pc;
      end
      S_FULL: begin
        if (pcsrce) begin
          imem_req  = 1'b1;
          imem_addr = target;
        end else if (!stallf) begin
          imem_req  = 1'b1;
          imem_addr = pc_next_seq;
        end
      end
      default: begin
        imem_req  = 1'b0;
        imem_addr = pc;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pc    <= word_align(RESET_PC);
      ibuf  <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pcsrce) pc <= target;
          if (imem_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (pcsrce) begin
            pc <= target;
            // A response landing in the redirect cycle is simply not captured.
            state <= imem_rvalid ? S_IDLE : S_DROP;
          end else if (imem_rvalid) begin
            ibuf  <= imem_rdata;
            state <= S_FULL;
          end
        end
        S_FULL: begin
          if (pcsrce) begin
            pc    <= target;
            state <= imem_ready ? S_WAIT : S_IDLE;
          end else if (!stallf) begin
            pc    <= pc_next_seq;
            state <= imem_ready ? S_WAIT : S_IDLE;
          end
        end
        S_DROP: begin
          if (pcsrce) pc <= target;
          if (imem_rvalid) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign fetch_valid = (state == S_FULL);
  assign rdf         = fetch_valid ? ibuf : NOP_INSTR;
  assign pcf         = pc;
  assign pcplus4f    = pc_next_seq;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stallf = 1'b0;
  logic        pcsrce = 1'b0;
  logic [31:0] pctargete = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] rdf;
  logic [31:0] pcf;
  logic [31:0] pcplus4f;
  logic        fetch_valid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  if_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stallf     (stallf),
    .pcsrce     (pcsrce),
    .pctargete  (pctargete),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .rdf        (rdf),
    .pcf        (pcf),
    .pcplus4f   (pcplus4f),
    .fetch_valid(fetch_valid)
  );

  typedef struct {
    logic        stall;
    logic        src;
    logic [31:0] tgt;
    logic        rdy;
    logic        rv;
    logic [31:0] rdata;
    logic        ereq;
    logic [31:0] eaddr;
    logic        efv;
    logic [31:0] erdf;
    logic [31:0] epcf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic stall, logic src, logic [31:0] tgt,
                              logic rdy, logic rv, logic [31:0] rdata,
                              logic ereq, logic [31:0] eaddr, logic efv,
                              logic [31:0] erdf, logic [31:0] epcf);
    vec_t v;
    v.stall = stall; v.src = src; v.tgt = tgt; v.rdy = rdy; v.rv = rv;
    v.rdata = rdata; v.ereq = ereq; v.eaddr = eaddr; v.efv = efv;
    v.erdf = erdf; v.epcf = epcf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic ereq, input logic [31:0] eaddr,
                             input logic efv, input logic [31:0] erdf, input logic [31:0] epcf);
    chk({tag, " imem_req"}, {31'd0, imem_req}, {31'd0, ereq});
    if (ereq) chk({tag, " imem_addr"}, imem_addr, eaddr);
    chk({tag, " fetch_valid"}, {31'd0, fetch_valid}, {31'd0, efv});
    chk({tag, " rdf"}, rdf, erdf);
    chk({tag, " pcf"}, pcf, epcf);
    chk({tag, " pcplus4f"}, pcplus4f, epcf + 32'd4);
  endtask

  initial begin
    //          stl src tgt           rdy rv rdata          req addr          fv rdf   pcf
    vecs.push_back(mk(0,0,32'h0,        1,0,32'h0,          1,32'h0,        0,NOP,32'h0));        // 0 IDLE, first req addr 0
    vecs.push_back(mk(0,0,32'h0,        1,1,32'h13,         0,32'h0,        0,NOP,32'h0));        // 1 WAIT, response
    vecs.push_back(mk(0,0,32'h0,        1,0,32'h0,          1,32'h4,        1,32'h13,32'h0));     // 2 FULL, fv rises
    vecs.push_back(mk(0,0,32'h0,        1,1,32'h14,         0,32'h0,        0,NOP,32'h4));
    vecs.push_back(mk(0,0,32'h0,        1,0,32'h0,          1,32'h8,        1,32'h14,32'h4));
    vecs.push_back(mk(0,0,32'h0,        1,1,32'h15,         0,32'h0,        0,NOP,32'h8));
    vecs.push_back(mk(1,0,32'h0,        1,0,32'h0,          0,32'h0,        1,32'h15,32'h8));     // 6-8 stall
    vecs.push_back(mk(1,0,32'h0,        1,0,32'h0,          0,32'h0,        1,32'h15,32'h8));
    vecs.push_back(mk(1,0,32'h0,        1,0,32'h0,          0,32'h0,        1,32'h15,32'h8));
    vecs.push_back(mk(0,0,32'h0,        1,0,32'h0,          1,32'hC,        1,32'h15,32'h8));     // 9 release -> 12
    vecs.push_back(mk(0,0,32'h0,        1,1,32'h16,         0,32'h0,        0,NOP,32'hC));
    vecs.push_back(mk(0,0,32'h0,        0,0,32'h0,          1,32'h10,       1,32'h16,32'hC));     // 11 advance, not ready
    vecs.push_back(mk(0,0,32'h0,        0,0,32'h0,          1,32'h10,       0,NOP,32'h10));       // 12-15 IDLE not ready
    vecs.push_back(mk(0,0,32'h0,        0,0,32'h0,          1,32'h10,       0,NOP,32'h10));
    vecs.push_back(mk(0,0,32'h0,        0,0,32'h0,          1,32'h10,       0,NOP,32'h10));
    vecs.push_back(mk(0,0,32'h0,        0,0,32'h0,          1,32'h10,       0,NOP,32'h10));
    vecs.push_back(mk(0,0,32'h0,        1,0,32'h0,          1,32'h10,       0,NOP,32'h10));       // 16 accepted
    vecs.push_back(mk(0,1,32'h100,      1,0,32'h0,          0,32'h0,        0,NOP,32'h10));       // 17 redirect in WAIT
    vecs.push_back(mk(0,0,32'h0,        1,1,32'hDEAD_BEEF,  0,32'h0,        0,NOP,32'h100));      // 18 DROP, discarded
    vecs.push_back(mk(0,0,32'h0,        1,0,32'h0,          1,32'h100,      0,NOP,32'h100));      // 19 req to target
    vecs.push_back(mk(0,0,32'h0,        1,1,32'h513,        0,32'h0,        0,NOP,32'h100));
    vecs.push_back(mk(1,1,32'h43,       1,0,32'h0,          1,32'h40,       1,32'h513,32'h100));  // 21 redirect beats stall
    vecs.push_back(mk(0,0,32'h0,        1,1,32'h777,        0,32'h0,        0,NOP,32'h40));
    vecs.push_back(mk(0,0,32'h0,        0,0,32'h0,          1,32'h44,       1,32'h777,32'h40));
    vecs.push_back(mk(0,0,32'h0,        0,1,32'hBAD,        1,32'h44,       0,NOP,32'h44));       // 24 spurious rvalid
    vecs.push_back(mk(0,1,32'h200,      0,0,32'h0,          1,32'h200,      0,NOP,32'h44));       // 25 redirect in IDLE
    vecs.push_back(mk(0,0,32'h0,        1,0,32'h0,          1,32'h200,      0,NOP,32'h200));
    vecs.push_back(mk(0,1,32'h300,      1,1,32'hAAA,        0,32'h0,        0,NOP,32'h200));      // 27 redirect + rvalid
    vecs.push_back(mk(0,0,32'h0,        1,0,32'h0,          1,32'h300,      0,NOP,32'h300));
    vecs.push_back(mk(0,0,32'h0,        1,0,32'h0,          0,32'h0,        0,NOP,32'h300));
    vecs.push_back(mk(0,1,32'h400,      1,0,32'h0,          0,32'h0,        0,NOP,32'h300));      // 30 -> DROP
    vecs.push_back(mk(0,1,32'h500,      1,0,32'h0,          0,32'h0,        0,NOP,32'h400));      // 31 latest target wins
    vecs.push_back(mk(0,0,32'h0,        1,1,32'hCCC,        0,32'h0,        0,NOP,32'h500));
    vecs.push_back(mk(0,0,32'h0,        1,0,32'h0,          1,32'h500,      0,NOP,32'h500));
    vecs.push_back(mk(0,0,32'h0,        1,1,32'h999,        0,32'h0,        0,NOP,32'h500));
    vecs.push_back(mk(1,0,32'h0,        1,0,32'h0,          0,32'h0,        1,32'h999,32'h500));
    vecs.push_back(mk(0,1,32'hFFFF_FFFC,1,0,32'h0,          1,32'hFFFF_FFFC,1,32'h999,32'h500));  // 36 to top of memory
    vecs.push_back(mk(0,0,32'h0,        1,1,32'h123,        0,32'h0,        0,NOP,32'hFFFF_FFFC));
    vecs.push_back(mk(0,0,32'h0,        1,0,32'h0,          1,32'h0,        1,32'h123,32'hFFFF_FFFC)); // 38 wrap
    vecs.push_back(mk(0,0,32'h0,        1,0,32'h0,          0,32'h0,        0,NOP,32'h0));
    vecs.push_back(mk(0,0,32'h0,        1,1,32'h321,        0,32'h0,        0,NOP,32'h0));
    vecs.push_back(mk(0,0,32'h0,        1,0,32'h0,          1,32'h4,        1,32'h321,32'h0));    // 41 -> WAIT pc=4

    // Reset state
    #12;
    chk_outputs("reset", 1'b1, 32'h0, 1'b0, NOP, 32'h0);

    @(posedge clk); #1;
    rst_n = 1'b1;
    foreach (vecs[i]) begin
      stallf      = vecs[i].stall;
      pcsrce      = vecs[i].src;
      pctargete   = vecs[i].tgt;
      imem_ready  = vecs[i].rdy;
      imem_rvalid = vecs[i].rv;
      imem_rdata  = vecs[i].rdata;
      @(negedge clk);
      chk_outputs($sformatf("vec%0d", i), vecs[i].ereq, vecs[i].eaddr,
                  vecs[i].efv, vecs[i].erdf, vecs[i].epcf);
      @(posedge clk); #1;
    end

    // Now in WAIT with pc=4 and a request outstanding; reset asynchronously.
    stallf = 1'b0; pcsrce = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0;
    #1;
    chk("pre_reset pcf", pcf, 32'h4);
    #1;
    rst_n = 1'b0;
    #1;
    chk_outputs("async_reset", 1'b1, 32'h0, 1'b0, NOP, 32'h0);
    // Late response for the forgotten request arrives across reset release.
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hFEED_F00D;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_outputs("late_rvalid", 1'b1, 32'h0, 1'b0, NOP, 32'h0);
    @(posedge clk); #1;
    imem_rvalid = 1'b0;
    imem_ready  = 1'b1;
    @(negedge clk);
    chk_outputs("post_reset_idle", 1'b1, 32'h0, 1'b0, NOP, 32'h0);
    @(posedge clk); #1;
    imem_ready = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'h0000_0093;
    @(negedge clk);
    chk_outputs("post_reset_wait", 1'b0, 32'h0, 1'b0, NOP, 32'h0);
    @(posedge clk); #1;
    imem_rvalid = 1'b0;
    @(negedge clk);
    chk_outputs("post_reset_full", 1'b1, 32'h4, 1'b1, 32'h0000_0093, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
